// File: rtl/avg_pix_sched.sv
// avg_pix_sched: frame-level scheduler around the combinational avg_pix filter.
// Loads raster rows into three rotating row buffers, builds each 3x3 window,
// presents it to avg_pix and streams filtered pixels out in raster order.
// Optional feature: define AVG_PIX_SCHED_REPLICATE_EN to replicate edge pixels
// into out-of-frame neighbours and filter border pixels like interior ones.
// Without it, out-of-frame neighbours read as 0 and border pixels pass through.
module avg_pix_sched #(
   parameter int IMG_W = 64,
   parameter int IMG_H = 48,
   parameter int PIX_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             done,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [PIX_W-1:0] in_pix,
   output logic [PIX_W-1:0] win_a,
   output logic [PIX_W-1:0] win_b,
   output logic [PIX_W-1:0] win_c,
   output logic [PIX_W-1:0] win_d,
   output logic [PIX_W-1:0] win_e,
   output logic [PIX_W-1:0] win_f,
   output logic [PIX_W-1:0] win_g,
   output logic [PIX_W-1:0] win_h,
   output logic [PIX_W-1:0] win_orig,
   input  logic [PIX_W-1:0] avg_new,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [PIX_W-1:0] out_pix,
   output logic             out_last
);

   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = $clog2(IMG_H + 1);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
   localparam logic [RW-1:0] ROW_CNT  = RW'(IMG_H);

   typedef enum logic [1:0] {IDLE, LOAD, PROC, DONE} state_t;

   typedef struct packed {
      logic [PIX_W-1:0] a, b, c, d, e, f, g, h, orig;
   } win_t;

   // Row r lives in buffer slot r mod 3; these step a slot index around the ring.
   function automatic logic [1:0] slot_next(input logic [1:0] s);
      return (s == 2'd2) ? 2'd0 : s + 2'd1;
   endfunction

   function automatic logic [1:0] slot_prev(input logic [1:0] s);
      return (s == 2'd0) ? 2'd2 : s - 2'd1;
   endfunction

   state_t            state_q, state_d;
   logic [CW-1:0]     col;        // column being loaded or presented
   logic [RW-1:0]     ld_row;     // next row to load (= rows loaded so far)
   logic [RW-1:0]     pr_row;     // row being filtered
   logic [1:0]        ld_slot;
   logic [1:0]        pr_slot;
   logic [PIX_W-1:0]  mem [3][IMG_W];
   win_t              win_q, nxt_win;
   logic              nxt_last;

   logic              load_hs, out_hs, load_row_end, proc_row_end, win_load;
   logic [CW-1:0]     nc, cl, cr;
   logic [1:0]        s_up, s_dn;
   logic              top, bot, lft, rgt;

   assign load_hs      = (state_q == LOAD) && in_valid;
   assign out_hs       = out_valid && out_ready;
   assign load_row_end = load_hs && (col == COL_LAST);
   assign proc_row_end = out_hs && (col == COL_LAST);
   // Load a window on the first PROC cycle of a row, then after each non-final handshake.
   assign win_load     = (state_q == PROC) &&
                         (!out_valid || (out_hs && (col != COL_LAST)));

   // State register; reset has priority over everything, including start.
   // NOTE: every clocked block uses non-blocking (<=) so all flops update together.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state decode and status outputs derived from the current state.
   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      state_d  = state_q;
      busy     = (state_q != IDLE);
      done     = (state_q == DONE);
      in_ready = (state_q == LOAD);
      case (state_q)
         IDLE: if (start) state_d = LOAD;
         LOAD: if (load_row_end) state_d = (ld_row == '0) ? LOAD : PROC;
         PROC: begin
            if (proc_row_end) begin
               if (pr_row == ROW_LAST)    state_d = DONE;
               else if (ld_row < ROW_CNT) state_d = LOAD;
               else                       state_d = PROC;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Column/row counters, buffer slot rotation and output-valid flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         col       <= '0;
         ld_row    <= '0;
         pr_row    <= '0;
         ld_slot   <= 2'd0;
         pr_slot   <= 2'd0;
         out_valid <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  col     <= '0;
                  ld_row  <= '0;
                  pr_row  <= '0;
                  ld_slot <= 2'd0;
                  pr_slot <= 2'd0;
               end
            end
            LOAD: begin
               if (load_row_end) begin
                  col     <= '0;
                  ld_row  <= ld_row + RW'(1);
                  ld_slot <= slot_next(ld_slot);
               end else if (load_hs) begin
                  col <= col + CW'(1);
               end
            end
            PROC: begin
               if (!out_valid) begin
                  col       <= '0;
                  out_valid <= 1'b1;
               end else if (proc_row_end) begin
                  col       <= '0;
                  out_valid <= 1'b0;
                  pr_row    <= pr_row + RW'(1);
                  pr_slot   <= slot_next(pr_slot);
               end else if (out_hs) begin
                  col <= col + CW'(1);
               end
            end
            default: out_valid <= 1'b0;
         endcase
      end
   end

   // Row buffer write port; one pixel per accepted input handshake.
   // NOTE: the buffers carry no reset; every location is rewritten before it is read.
   always_ff @(posedge clk) begin
      if (load_hs) mem[ld_slot][col] <= in_pix;
   end

   // Assemble the window for the next column to present, with edge handling.
   always_comb begin
      nc   = (out_valid && (col != COL_LAST)) ? col + CW'(1) : '0;
      top  = (pr_row == '0);
      bot  = (pr_row == ROW_LAST);
      lft  = (nc == '0);
      rgt  = (nc == COL_LAST);
      cl   = lft ? nc : nc - CW'(1);
      cr   = rgt ? nc : nc + CW'(1);
      s_up = top ? pr_slot : slot_prev(pr_slot);
      s_dn = bot ? pr_slot : slot_next(pr_slot);
      nxt_win.a    = mem[s_up][cl];
      nxt_win.b    = mem[s_up][nc];
      nxt_win.c    = mem[s_up][cr];
      nxt_win.d    = mem[pr_slot][cl];
      nxt_win.e    = mem[pr_slot][cr];
      nxt_win.f    = mem[s_dn][cl];
      nxt_win.g    = mem[s_dn][nc];
      nxt_win.h    = mem[s_dn][cr];
      nxt_win.orig = mem[pr_slot][nc];
`ifdef AVG_PIX_SCHED_REPLICATE_EN
      // Clamped row/column indices above already replicate the nearest edge pixel.
`else
      if (top) begin
         nxt_win.a = '0;
         nxt_win.b = '0;
         nxt_win.c = '0;
      end
      if (bot) begin
         nxt_win.f = '0;
         nxt_win.g = '0;
         nxt_win.h = '0;
      end
      if (lft) begin
         nxt_win.a = '0;
         nxt_win.d = '0;
         nxt_win.f = '0;
      end
      if (rgt) begin
         nxt_win.c = '0;
         nxt_win.e = '0;
         nxt_win.h = '0;
      end
`endif
      nxt_last = bot && rgt;
   end

   // Window and last-pixel registers; held while the consumer stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         win_q    <= '0;
         out_last <= 1'b0;
      end else if (win_load) begin
         win_q    <= nxt_win;
         out_last <= nxt_last;
      end
   end

   assign win_a    = win_q.a;
   assign win_b    = win_q.b;
   assign win_c    = win_q.c;
   assign win_d    = win_q.d;
   assign win_e    = win_q.e;
   assign win_f    = win_q.f;
   assign win_g    = win_q.g;
   assign win_h    = win_q.h;
   assign win_orig = win_q.orig;

`ifdef AVG_PIX_SCHED_REPLICATE_EN
   assign out_pix = avg_new;
`else
   logic border_q;

   // Remember whether the presented pixel sits on the frame border.
   always_ff @(posedge clk) begin
      if (rst)           border_q <= 1'b0;
      else if (win_load) border_q <= top || bot || lft || rgt;
   end

   assign out_pix = border_q ? win_q.orig : avg_new;
`endif

endmodule

// File: tb/tb_avg_pix_sched.sv
// tb_avg_pix_sched: randomized self-checking bench for avg_pix_sched on a 4x3 frame.
// A stub of avg_pix (mean of the 8 neighbours) closes the loop; expected windows
// and outputs come from a frame-level model indexed by (row, column).
module tb_avg_pix_sched;

   localparam int W = 4;
   localparam int H = 3;
   localparam int P = 8;
   localparam int N = W * H;
   localparam int BUDGET = 2000;

   logic         clk, rst, start, busy, done;
   logic         in_valid, in_ready;
   logic [P-1:0] in_pix;
   logic [P-1:0] win_a, win_b, win_c, win_d, win_e, win_f, win_g, win_h, win_orig;
   logic [P-1:0] avg_new, out_pix;
   logic         out_valid, out_ready, out_last;
   logic [10:0]  nb_sum;
   logic [71:0]  win_all;

   int n_total = 0;
   int n_bad   = 0;

   logic [P-1:0] frame [N];

   avg_pix_sched #(.IMG_W(W), .IMG_H(H), .PIX_W(P)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix),
      .win_a(win_a), .win_b(win_b), .win_c(win_c), .win_d(win_d),
      .win_e(win_e), .win_f(win_f), .win_g(win_g), .win_h(win_h),
      .win_orig(win_orig), .avg_new(avg_new),
      .out_valid(out_valid), .out_ready(out_ready), .out_pix(out_pix),
      .out_last(out_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // avg_pix stand-in: mean of the eight neighbours.
   always_comb begin
      nb_sum  = 11'(win_a) + 11'(win_b) + 11'(win_c) + 11'(win_d) +
                11'(win_e) + 11'(win_f) + 11'(win_g) + 11'(win_h);
      avg_new = nb_sum[10:3];
   end

   assign win_all = {win_a, win_b, win_c, win_d, win_e, win_f, win_g, win_h, win_orig};

   task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: pixel at (r,c), with out-of-frame handling.
   function automatic logic [P-1:0] px(input int r, input int c);
`ifdef AVG_PIX_SCHED_REPLICATE_EN
      int rr = (r < 0) ? 0 : (r >= H) ? H - 1 : r;
      int cc = (c < 0) ? 0 : (c >= W) ? W - 1 : c;
      return frame[rr * W + cc];
`else
      if (r < 0 || r >= H || c < 0 || c >= W) return '0;
      return frame[r * W + c];
`endif
   endfunction

   function automatic logic [71:0] mwin(input int r, input int c);
      return {px(r-1, c-1), px(r-1, c), px(r-1, c+1), px(r, c-1), px(r, c+1),
              px(r+1, c-1), px(r+1, c), px(r+1, c+1), px(r, c)};
   endfunction

   function automatic logic [P-1:0] mout(input int r, input int c);
      logic [71:0] w = mwin(r, c);
      int s = 0;
      bit border = (r == 0) || (r == H - 1) || (c == 0) || (c == W - 1);
      for (int k = 1; k <= 8; k++) s += int'(w[8*k +: 8]);
`ifdef AVG_PIX_SCHED_REPLICATE_EN
      border = 1'b0;
`endif
      return border ? w[7:0] : P'(s / 8);
   endfunction

   task automatic check_reset_values(input string tag);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_done"}, done, 1'b0);
      check({tag, "_in_ready"}, in_ready, 1'b0);
      check({tag, "_out_valid"}, out_valid, 1'b0);
      check({tag, "_out_last"}, out_last, 1'b0);
      check({tag, "_win"}, win_all, 72'h0);
   endtask

   // gap_mode: 0 none, 1 alternate cycles, 2 random. ready_mode: 0 always,
   // 1 random, 2 five-cycle stall at pixel (0,2). abort_at >= 0: reset when
   // that output index is presented.
   task automatic run_frame(input int gap_mode, input int ready_mode, input int abort_at);
      int in_idx = 0, out_idx = 0, cyc = 0, last_hs = -10, hold = 0;
      bit prev_stall = 0, prev_hs = 0, seen_done = 0, hs;
      logic [80:0] snap, prev_snap;
      int r, c;
      prev_snap = '0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_busy", busy, 1'b1);
      check("start_in_ready", in_ready, 1'b1);
      forever begin
         snap = {win_all, out_pix, out_last};
         if (prev_stall) check("hold_stable", snap, prev_snap);
         if (out_valid) check("in_ready_proc", in_ready, 1'b0);
         if (seen_done) begin
            check("busy_after_done", busy, 1'b0);
            check("done_pulse", done, 1'b0);
            check("in_count", in_idx, N);
            in_valid  = 1'b0;
            out_ready = 1'b0;
            break;
         end
         if (done) begin
            check("done_time", cyc, last_hs + 1);
            check("done_count", out_idx, N);
            seen_done = 1;
         end
         if (abort_at >= 0 && out_idx == abort_at && out_valid) begin
            rst      = 1'b1;
            start    = 1'b1;
            in_valid = 1'b1;
            @(negedge clk);
            rst   = 1'b0;
            start = 1'b0;
            in_valid = 1'b0;
            check_reset_values("abort");
            @(negedge clk);
            check("abort_idle_busy", busy, 1'b0);
            return;
         end
         case (gap_mode)
            0:       in_valid = (in_idx < N);
            1:       in_valid = (in_idx < N) && (cyc % 2 == 1);
            default: in_valid = (in_idx < N) && ($urandom_range(0, 1) == 1);
         endcase
         in_pix = in_valid ? frame[in_idx] : P'($urandom);
         case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = !(out_idx == 2 && hold < 5);
         endcase
         if (ready_mode == 2 && out_valid && !out_ready) hold++;
         if (in_valid && in_ready) in_idx++;
         hs = out_valid && out_ready;
         if (hs) begin
            r = out_idx / W;
            c = out_idx % W;
            check($sformatf("win_r%0d_c%0d", r, c), win_all, mwin(r, c));
            check($sformatf("pix_r%0d_c%0d", r, c), out_pix, mout(r, c));
            check($sformatf("last_r%0d_c%0d", r, c), out_last, out_idx == N - 1);
            if (ready_mode == 0 && c > 0) check("throughput", prev_hs, 1'b1);
            last_hs = cyc;
            out_idx++;
         end
         prev_stall = out_valid && !out_ready;
         prev_snap  = snap;
         prev_hs    = hs;
         cyc++;
         if (cyc > BUDGET) begin
            check("timeout_outputs", out_idx, N);
            in_valid  = 1'b0;
            out_ready = 1'b0;
            break;
         end
         @(negedge clk);
      end
      if (ready_mode == 2) check("stall_cycles", hold, 5);
   endtask

   task automatic fill_random();
      for (int i = 0; i < N; i++) frame[i] = P'($urandom);
   endtask

   initial begin
      rst = 1'b1; start = 1'b1; in_valid = 1'b0; in_pix = '0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      rst = 1'b0; start = 1'b0;

      // All-zero frame.
      for (int i = 0; i < N; i++) frame[i] = '0;
      run_frame(0, 0, -1);

      // Single bright pixel at (1,1).
      frame[1 * W + 1] = 8'hFF;
      run_frame(0, 0, -1);

      // Consumer stall at (0,2).
      fill_random();
      run_frame(0, 2, -1);

      // Same frame gap-free then with input gaps every other cycle.
      fill_random();
      run_frame(0, 0, -1);
      run_frame(1, 0, -1);

      // Reset during PROC of row 1, then a fresh frame.
      fill_random();
      run_frame(0, 0, W);
      fill_random();
      run_frame(0, 0, -1);

      // Ramp frame p(r,c) = 16r + c under random gaps and stalls.
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) frame[r * W + c] = P'(16 * r + c);
      run_frame(2, 1, -1);

      // Random frames with random flow control.
      for (int k = 0; k < 4; k++) begin
         fill_random();
         run_frame(2, 1, -1);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
